instruction_fetch: RTL

- Fetch stage sitting directly upstream of program_memory.
- Owns the program counter and drives the memory word address; memory read is combinational.
- Registers the returned instruction and its byte PC into an output slot (IF/ID register) with a valid/ready handshake toward decode.
- Accepts redirects (branch/jump targets) from execute and flushes the in-flight instruction.

---
 rtl/instruction_fetch_pkg.sv | 30 +++
 rtl/instruction_fetch_slot_reg.sv | 47 ++++
 rtl/instruction_fetch.sv | 114 +++++++++++
 3 files changed

// File: rtl/instruction_fetch_pkg.sv
// -----------------------------------------------------------------------------
// instruction_fetch_pkg
// Shared types and constants for the fetch stage.
//   fetch_state_t : 2-bit fetch state encodings (FETCH_RUN, FETCH_FAULT,
//                   FETCH_HALT). FETCH_HALT is only reachable when the
//                   FETCH_HALT_ON_ZERO_EN macro is defined.
//   INSTR_ZERO    : the all-zero instruction word.
//   fetch_slot_t  : payload held in the IF/ID output slot.
//   misaligned()  : true when a byte address is not word aligned.
// -----------------------------------------------------------------------------
package instruction_fetch_pkg;

  typedef enum logic [1:0] {
    FETCH_RUN   = 2'd0,
    FETCH_FAULT = 2'd1,
    FETCH_HALT  = 2'd2
  } fetch_state_t;

  localparam logic [31:0] INSTR_ZERO = 32'b0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_slot_t;

  function automatic logic misaligned(input logic [31:0] byte_addr);
    return byte_addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/instruction_fetch_slot_reg.sv
// -----------------------------------------------------------------------------
// fetch_slot_reg
// Single-entry valid/ready pipeline register with a flush input, meant to be
// reused for later pipeline registers.
//   clk, rst   : clock, synchronous active-high reset (clears valid and data)
//   flush      : drop the held entry this edge (highest priority after rst)
//   load       : capture in_data; caller asserts it only while free=1
//   in_data    : payload to capture
//   out_ready  : consumer accepts the held entry this cycle
//   free       : slot can take a new entry this cycle (!out_valid || out_ready)
//   out_valid  : slot holds an entry
//   out_data   : held payload; stable while out_valid && !out_ready
// -----------------------------------------------------------------------------
module fetch_slot_reg #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             load,
  input  logic [WIDTH-1:0] in_data,
  input  logic             out_ready,
  output logic             free,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  assign free = !out_valid || out_ready;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; the payload is reset too because downstream observes it
  // directly after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
// Fetch stage directly upstream of a combinational-read program memory. Owns
// the word PC, registers the returned word and its byte PC into an IF/ID slot
// with a valid/ready handshake, and accepts redirects from execute.
// Optional feature macro: FETCH_HALT_ON_ZERO_EN -- an all-zero word is still
// delivered but stops further fetching (HALT) until an aligned redirect.
//   clk, rst        : clock, synchronous active-high reset
//   imem_addr       : word address to program memory (the PC register)
//   imem_data       : instruction word for imem_addr, combinational
//   redirect_valid  : execute requests a PC change this cycle
//   redirect_target : byte address of the new PC
//   out_ready       : decode accepts the slot this cycle
//   out_valid       : slot holds a valid instruction
//   instr           : registered instruction word
//   instr_pc        : byte address of instr, zero-extended
//   fetch_fault     : sticky misaligned-redirect flag (cleared only by rst)
// -----------------------------------------------------------------------------
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int                    PC_WIDTH = 12,
  parameter logic [PC_WIDTH-1:0]   RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic [31:0]         imem_data,
  input  logic                redirect_valid,
  input  logic [31:0]         redirect_target,
  input  logic                out_ready,
  output logic                out_valid,
  output logic [31:0]         instr,
  output logic [31:0]         instr_pc,
  output logic                fetch_fault
);

  fetch_state_t          state_q, state_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic                  flush, load, slot_free;
  fetch_slot_t           capture, slot_q;

  // Only the word-index bits of the target reach the PC.
  logic unused_target;
  assign unused_target = ^redirect_target[31:PC_WIDTH+2];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH_RUN;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // NOTE: every combinational output gets a default before any branch, so no
  // path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    flush   = 1'b0;
    load    = 1'b0;
    if (state_q != FETCH_FAULT) begin
      if (redirect_valid) begin
        // A redirect always kills the slot, even if decode consumes it now.
        flush = 1'b1;
        if (misaligned(redirect_target)) begin
          state_d = FETCH_FAULT;
        end else begin
          pc_d    = redirect_target[PC_WIDTH+1:2];
          state_d = FETCH_RUN;
        end
      end else if (state_q == FETCH_RUN && slot_free) begin
        load = 1'b1;
`ifdef FETCH_HALT_ON_ZERO_EN
        if (imem_data == INSTR_ZERO) begin
          state_d = FETCH_HALT;
        end else begin
          pc_d = pc_q + PC_WIDTH'(1);
        end
`else
        pc_d = pc_q + PC_WIDTH'(1);
`endif
      end
    end
  end

  always_comb begin
    capture                  = '0;
    capture.pc[PC_WIDTH+1:0] = {pc_q, 2'b00};
    capture.instr            = imem_data;
  end

  fetch_slot_reg #(
    .WIDTH($bits(fetch_slot_t))
  ) u_slot (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .load      (load),
    .in_data   (capture),
    .out_ready (out_ready),
    .free      (slot_free),
    .out_valid (out_valid),
    .out_data  (slot_q)
  );

  assign imem_addr   = pc_q;
  assign instr       = slot_q.instr;
  assign instr_pc    = slot_q.pc;
  assign fetch_fault = (state_q == FETCH_FAULT);

endmodule
